data_mem_bank: RTL and testbench
================================

Name: data_mem_bank

Overview:
Parametrised, byte-addressable little-endian data memory for the dnnCpu load/store path. It supersedes the fixed 32-bit, word-only memory. It adds:
- byte, half and word access sizes, with signed or unsigned load extension
- a valid/ready request channel and a registered one-cycle response channel
- error reporting for misaligned, out-of-range and reserved-size accesses
- an optional post-reset clear sweep of the whole array

Parameters:
DEPTH_BYTES, 1024, array size in bytes; multiple of 4, power of two.
ADDR_W, 32, request address width.
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before accepting requests; 0 = skip the sweep.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_write  input  1  1 = store, 0 = load.
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data; only the low 8/16/32 bits are used, per size.
rsp_valid  output  1  response pulse, one cycle.
rsp_rdata  output  32  load result; 0 for stores and for errors.
rsp_err  output  1  access rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=INIT, clr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not reset asynchronously.
  - A reset mid-operation drops any pending response and restarts INIT.
- FSM states: INIT, RUN.
- INIT with CLEAR_ON_RESET=1:
  - Each clock writes 32'h0 to word clr_ptr, then increments clr_ptr.
  - After word DEPTH_BYTES/4-1 is written, the FSM moves to RUN.
  - The sweep takes exactly DEPTH_BYTES/4 cycles; req_ready=0 throughout.
- INIT with CLEAR_ON_RESET=0: moves to RUN on the first clock after reset release.
- RUN: req_ready=1 constantly.
- Acceptance: a request is accepted on a clock edge with req_valid && req_ready.
- Response timing:
  - rsp_valid=1 in the cycle after acceptance; otherwise rsp_valid=0.
  - rsp_rdata and rsp_err hold their values until the next response.
  - There is no response backpressure.
  - Back-to-back requests are accepted every cycle, so throughput is 1 per cycle.
- Error checks, evaluated at acceptance:
  - size 11 is an error.
  - half with addr[0]!=0 is an error.
  - word with addr[1:0]!=0 is an error.
  - addr + nbytes > DEPTH_BYTES is an error. The comparison is done in ADDR_W+1 bits, so no wrap-around occurs.
  - On error: no array write, rsp_err=1, rsp_rdata=0.
- Store:
  - Writes nbytes bytes at the accepting edge, with req_wdata[7:0] going to addr, [15:8] to addr+1, and so on.
  - Other bytes of the word are unchanged.
  - Response: rsp_err=0, rsp_rdata=0.
- Load:
  - Reads nbytes bytes, with the byte at addr in rsp_rdata[7:0].
  - Byte and half results are sign- or zero-extended to 32 bits according to req_unsigned.
  - The result is registered, giving one-cycle latency.
- Ordering: a store accepted on cycle N is visible to a load accepted on cycle N+1.
- Storage: the array is organised as DEPTH_BYTES/4 words with per-byte write enables. The array is not reset.

Test Plan:
1. Reset sweep, CLEAR_ON_RESET=1, DEPTH_BYTES=1024 -> req_ready stays 0 for 256 cycles after rst rises. A subsequent word load at 0x3FC returns 0x00000000 with rsp_err=0.
2. Word store 0x8BADF00D @0x10, then byte loads @0x10..0x13 -> responses:
   - unsigned: 0x0D, 0xF0, 0xAD, 0x8B
   - signed load @0x13 returns 0xFFFFFF8B
3. Half store 0x1234 @0x12 over the word from scenario 2 -> word load @0x10 returns 0x1234F00D. Signed half load @0x12 returns 0x00001234.
4. Errors -> each returns rsp_err=1, rsp_rdata=0, and a follow-up word load @0x10 still returns 0x1234F00D:
   - word store @0x11
   - half load @0x13
   - size 11 @0x10
   - word store @0x3FE
   - word load @0x400
5. Back-to-back requests, req_valid held high for 4 cycles (store @0x20 = 0xA5A5A5A5, load @0x20, load @0x24, store @0x24) -> 4 consecutive rsp_valid pulses. The load @0x20 returns 0xA5A5A5A5.
6. rst asserted one cycle after a load is accepted -> no rsp_valid pulse, all outputs 0 immediately, and the INIT sweep restarts.

Source files
------------

// File: rtl/data_mem_bank.sv
// data_mem_bank: byte-addressable little-endian data memory for the dnnCpu
// load/store path. Byte/half/word accesses with a valid/ready request channel,
// a registered one-cycle response, error reporting and an optional post-reset
// clear sweep of the whole array.
module data_mem_bank #(
   parameter int DEPTH_BYTES    = 1024,
   parameter int ADDR_W         = 32,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int              WORDS     = DEPTH_BYTES / 4;
   localparam int              IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   // Storage: one 32-bit word per entry, byte lanes written individually.
   logic [31:0]       mem_q [WORDS];

   logic              accept_s;
   logic [ADDR_W:0]   nbytes_s;
   logic [ADDR_W:0]   end_s;
   logic              size_err_s;
   logic              misalign_s;
   logic              err_s;
   logic [IDX_W-1:0]  idx_s;
   logic [31:0]       rword_s;
   logic [7:0]        byte_s;
   logic [15:0]       half_s;
   logic [31:0]       load_s;
   logic              wr_en_s;
   logic [IDX_W-1:0]  wr_idx_s;
   logic [3:0]        wr_be_s;
   logic [31:0]       wr_data_s;

   assign accept_s = req_valid & ready_q;
   assign idx_s    = req_addr[IDX_W+1:2];

   // Decode the access size and flag reserved-size, misaligned and out-of-range requests.
   always_comb begin
      nbytes_s   = '0;
      size_err_s = 1'b0;
      misalign_s = 1'b0;
      case (req_size)
         2'b00: begin
            nbytes_s = (ADDR_W + 1)'(1);
         end
         2'b01: begin
            nbytes_s   = (ADDR_W + 1)'(2);
            misalign_s = req_addr[0];
         end
         2'b10: begin
            nbytes_s   = (ADDR_W + 1)'(4);
            misalign_s = (req_addr[1:0] != 2'b00);
         end
         default: begin
            size_err_s = 1'b1;
         end
      endcase
      // One extra bit keeps addresses near the top of the space from wrapping.
      end_s = {1'b0, req_addr} + nbytes_s;
      err_s = size_err_s | misalign_s | (end_s > DEPTH_EXT);
   end

   // Extract the addressed byte/half/word and apply sign or zero extension.
   always_comb begin
      rword_s = mem_q[idx_s];
      byte_s  = rword_s[{req_addr[1:0], 3'b000} +: 8];
      half_s  = rword_s[{req_addr[1], 4'b0000} +: 16];
      load_s  = 32'h0;
      case (req_size)
         2'b00:   load_s = req_unsigned ? {24'h0, byte_s} : {{24{byte_s[7]}}, byte_s};
         2'b01:   load_s = req_unsigned ? {16'h0, half_s} : {{16{half_s[15]}}, half_s};
         2'b10:   load_s = rword_s;
         default: load_s = 32'h0;
      endcase
   end

   // Select the array write: clear sweep during INIT, otherwise a legal store.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = idx_s;
      wr_be_s   = 4'b0000;
      wr_data_s = 32'h0;
      if (state_q == ST_INIT) begin
         if (CLEAR_ON_RESET) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = clr_ptr_q;
            wr_be_s   = 4'b1111;
            wr_data_s = 32'h0;
         end else begin
            wr_en_s = 1'b0;
         end
      end else if (accept_s && req_write && !err_s) begin
         wr_en_s = 1'b1;
         case (req_size)
            2'b00: begin
               wr_be_s   = 4'b0001 << req_addr[1:0];
               wr_data_s = {4{req_wdata[7:0]}};
            end
            2'b01: begin
               wr_be_s   = req_addr[1] ? 4'b1100 : 4'b0011;
               wr_data_s = {2{req_wdata[15:0]}};
            end
            2'b10: begin
               wr_be_s   = 4'b1111;
               wr_data_s = req_wdata;
            end
            default: begin
               wr_be_s   = 4'b0000;
               wr_data_s = 32'h0;
            end
         endcase
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Next-state logic: sweep the array in INIT, then stay in RUN.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         ST_INIT: begin
            if (CLEAR_ON_RESET) begin
               clr_ptr_d = clr_ptr_q + IDX_W'(1);
               if (clr_ptr_q == LAST_IDX) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_INIT;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
      ready_d = (state_d == ST_RUN);
   end

   // Response: pulse valid after acceptance; data and error hold until the next response.
   always_comb begin
      rsp_valid_d = accept_s;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (accept_s) begin
         if (err_s) begin
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
         end else if (req_write) begin
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
         end else begin
            rsp_rdata_d = load_s;
            rsp_err_d   = 1'b0;
         end
      end else begin
         rsp_rdata_d = rsp_rdata_q;
      end
   end

   // Control and response registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_INIT;
         clr_ptr_q   <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Array write port with per-byte enables; contents are never reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en_s && wr_be_s[i]) begin
            mem_q[wr_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
         end
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// tb_data_mem_bank: self-checking bench for data_mem_bank. A byte-array
// reference model predicts every response; directed scenarios are followed
// by randomized traffic and a mid-operation reset.
module tb_data_mem_bank;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [7:0]  ref_mem [DEPTH];
   logic [31:0] last_rdata;
   logic        last_err;
   logic        exp_ready;

   data_mem_bank #(
      .DEPTH_BYTES   (DEPTH),
      .ADDR_W        (32),
      .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_size    (req_size),
      .req_unsigned(req_unsigned),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: applies one accepted request to the byte array.
   function automatic void model_access(input logic w, input logic [1:0] sz, input logic u,
                                        input logic [31:0] a, input logic [31:0] wd,
                                        output logic [31:0] rd, output logic er);
      int              nb;
      longint unsigned ea;
      logic [31:0]     v;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      ea = {32'h0, a};
      er = (sz == 2'd3) || (nb > 1 && (ea % nb) != 0) || (ea + nb > DEPTH);
      rd = 32'h0;
      v  = 32'h0;
      if (!er) begin
         if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[ea + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < nb; i++) v = v | ({24'h0, ref_mem[ea + i]} << (8 * i));
            if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            rd = v;
         end
      end
   endfunction

   // One clock of stimulus, entered and left at a falling edge.
   task automatic cycle(input logic v, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
      logic        acc;
      logic [31:0] erd;
      logic        eer;
      req_valid    = v;
      req_write    = w;
      req_size     = sz;
      req_unsigned = u;
      req_addr     = a;
      req_wdata    = wd;
      check_eq({tag, " ready"}, {31'h0, req_ready}, {31'h0, exp_ready});
      acc = v && exp_ready;
      @(posedge clk);
      if (acc) begin
         model_access(w, sz, u, a, wd, erd, eer);
         last_rdata = erd;
         last_err   = eer;
      end
      @(negedge clk);
      req_valid = 1'b0;
      check_eq({tag, " valid"}, {31'h0, rsp_valid}, {31'h0, acc});
      check_eq({tag, " rdata"}, rsp_rdata, last_rdata);
      check_eq({tag, " err"}, {31'h0, rsp_err}, {31'h0, last_err});
   endtask

   task automatic do_reset(input string tag);
      int cnt;
      rst       = 1'b0;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq({tag, " rst ready"}, {31'h0, req_ready}, 32'h0);
      check_eq({tag, " rst valid"}, {31'h0, rsp_valid}, 32'h0);
      check_eq({tag, " rst rdata"}, rsp_rdata, 32'h0);
      check_eq({tag, " rst err"}, {31'h0, rsp_err}, 32'h0);
      rst = 1'b1;
      cnt = 0;
      while (!req_ready && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      check_eq({tag, " sweep cycles"}, cnt, 32'd256);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      last_rdata = 32'h0;
      last_err   = 1'b0;
      exp_ready  = 1'b1;
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      rst          = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      exp_ready    = 1'b0;
      last_rdata   = 32'h0;
      last_err     = 1'b0;
      @(negedge clk);
      do_reset("s1");

      // Scenario 1: top word after the sweep.
      cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, "s1 ld 3fc");

      // Scenario 2: word store, byte loads.
      cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8BAD_F00D, "s2 st");
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 2'd0, 1'b1, 32'h10 + i, 32'h0, "s2 ldbu");
      cycle(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "s2 ldb");
      check_eq("s2 const", rsp_rdata, 32'hFFFF_FF8B);

      // Scenario 3: half store over the upper half.
      cycle(1'b1, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, "s3 sth");
      cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "s3 ldw");
      check_eq("s3 const", rsp_rdata, 32'h1234_F00D);
      cycle(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "s3 ldh");

      // Scenario 4: rejected accesses leave memory unchanged.
      cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h11, 32'hFFFF_FFFF, "s4 st mis");
      cycle(1'b1, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, "s4 ld mis");
      cycle(1'b1, 1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF, "s4 size");
      cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h3FE, 32'hFFFF_FFFF, "s4 st oob");
      cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, "s4 ld oob");
      check_eq("s4 err const", {31'h0, rsp_err}, 32'h1);
      cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "s4 ldw");
      check_eq("s4 const", rsp_rdata, 32'h1234_F00D);

      // Scenario 5: back-to-back requests.
      cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5_A5A5, "s5 st20");
      cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "s5 ld20");
      check_eq("s5 const", rsp_rdata, 32'hA5A5_A5A5);
      cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, "s5 ld24");
      cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h24, 32'h5A5A_0001, "s5 st24");
      cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, "s5 idle");

      // Randomized traffic including wrap-around addresses near 2^32.
      for (int n = 0; n < 600; n++) begin
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0:       a = 32'($urandom_range(1000, 1100));
            1:       a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            default: a = 32'($urandom_range(0, 127));
         endcase
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
            else if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
            else a = a;
         end
         cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), sz,
               1'($urandom_range(0, 1)), a, $urandom, "rnd");
      end

      // Scenario 6: reset right after a load is accepted.
      cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_BABE, "s6 st");
      req_valid    = 1'b1;
      req_write    = 1'b0;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      req_addr     = 32'h10;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      req_valid = 1'b0;
      check_eq("s6 ready", {31'h0, req_ready}, 32'h0);
      check_eq("s6 valid", {31'h0, rsp_valid}, 32'h0);
      check_eq("s6 rdata", rsp_rdata, 32'h0);
      check_eq("s6 err", {31'h0, rsp_err}, 32'h0);
      exp_ready = 1'b0;
      @(negedge clk);
      check_eq("s6 no pulse", {31'h0, rsp_valid}, 32'h0);
      do_reset("s6");
      cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "s6 ld10");
      cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "s6 ld20");
      check_eq("s6 cleared", rsp_rdata, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
